// File: rtl/ife_block_packer_pkg.sv
// rtl/ife_block_packer_pkg.sv - shared types, constants and lane padding helper for the block packer
package ife_pkg;

  localparam int IFE_LANES = 4;
  localparam int IFE_ID_W  = 8;
  localparam logic [31:0] IFE_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [IFE_ID_W-1:0]             id;
    logic [IFE_LANES-1:0][31:0]      data;
  } ife_block_t;

  typedef enum logic {
    FLUSH_IDLE    = 1'b0,
    FLUSH_PENDING = 1'b1
  } flush_state_e;

  // Lanes at or above 'fill' become NOPs; lane 3 is never held in the lane register.
  function automatic logic [IFE_LANES-1:0][31:0] ife_pad_lanes(
    input logic [2:0][31:0] lanes,
    input logic [1:0]       fill
  );
    logic [IFE_LANES-1:0][31:0] data;
    data = {IFE_LANES{IFE_NOP}};
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < fill) data[i] = lanes[i];
    end
    return data;
  endfunction

endpackage

// File: rtl/ife_block_packer_if.sv
// rtl/ife_block_packer_if.sv - instruction input, block output and status bundle of the packer
interface ife_block_packer_if #(
  parameter int ID_W  = 8,
  parameter int CNT_W = 3
) ();

  logic [31:0]                               instr_in;
  logic                                      instr_valid;
  logic                                      instr_ready;
  logic                                      flush;
  logic [ID_W-1:0]                           block_id_out;
  logic [ife_pkg::IFE_LANES-1:0][31:0]       block_data_out;
  logic                                      block_valid_out;
  logic                                      block_ready_in;
  logic [CNT_W-1:0]                          fifo_count;
  logic                                      flush_pending;

  modport master (
    output instr_in, instr_valid, flush, block_ready_in,
    input  instr_ready, block_id_out, block_data_out, block_valid_out,
    input  fifo_count, flush_pending
  );

  modport slave (
    input  instr_in, instr_valid, flush, block_ready_in,
    output instr_ready, block_id_out, block_data_out, block_valid_out,
    output fifo_count, flush_pending
  );

endinterface

// File: rtl/ife_block_packer_fifo.sv
// rtl/ife_block_packer_fifo.sv - synchronous FIFO of completed instruction blocks
module ife_block_fifo
  import ife_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  ife_block_t       data_i,
  input  logic             pop_i,
  output ife_block_t       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  ife_block_t        mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ife_block_packer.sv
// rtl/ife_block_packer.sv - packs 32-bit instructions into ID-tagged 4-lane blocks with flush padding
module ife_block_packer
  import ife_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 8
) (
  input logic               clk,
  input logic               rst,
  ife_block_packer_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  flush_state_e      state_q, state_d;
  logic [1:0]        lane_cnt_q, lane_cnt_d;
  logic [2:0][31:0]  lanes_q, lanes_d;
  logic [ID_W-1:0]   next_id_q, next_id_d;

  logic              instr_ready;
  logic              accept;
  logic              push;
  logic              pop;
  ife_block_t        push_blk;
  ife_block_t        head_blk;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FLUSH_IDLE;
      lane_cnt_q <= '0;
      lanes_q    <= '0;
      next_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      lanes_q    <= lanes_d;
      next_id_q  <= next_id_d;
    end
  end

  // Readiness depends only on registered state so the consumer never sees a loop through us.
  assign instr_ready = (state_q == FLUSH_IDLE) && ((lane_cnt_q != 2'd3) || !fifo_full);
  assign accept      = bus.instr_valid && instr_ready;

  always_comb begin
    state_d       = state_q;
    lane_cnt_d    = lane_cnt_q;
    lanes_d       = lanes_q;
    next_id_d     = next_id_q;
    push          = 1'b0;
    push_blk.id   = IFE_ID_W'(next_id_q);
    push_blk.data = {bus.instr_in, lanes_q[2], lanes_q[1], lanes_q[0]};

    case (state_q)
      FLUSH_IDLE: begin
        if (accept) begin
          if (lane_cnt_q == 2'd3) begin
            push       = 1'b1;
            lane_cnt_d = 2'd0;
            next_id_d  = next_id_q + 1'b1;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (lane_cnt_q == 2'(i)) lanes_d[i] = bus.instr_in;
            end
            lane_cnt_d = lane_cnt_q + 2'd1;
          end
        end
        if (bus.flush) state_d = FLUSH_PENDING;
      end
      FLUSH_PENDING: begin
        if (!fifo_full) begin
          state_d = FLUSH_IDLE;
          if (lane_cnt_q != 2'd0) begin
            push          = 1'b1;
            push_blk.data = ife_pad_lanes(lanes_q, lane_cnt_q);
            lane_cnt_d    = 2'd0;
            next_id_d     = next_id_q + 1'b1;
          end
        end
      end
      default: state_d = FLUSH_IDLE;
    endcase
  end

  assign pop = !fifo_empty && bus.block_ready_in;

  ife_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_blk),
    .pop_i   (pop),
    .head_o  (head_blk),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.instr_ready     = instr_ready;
  assign bus.block_valid_out = !fifo_empty;
  assign bus.block_id_out    = ID_W'(head_blk.id);
  assign bus.block_data_out  = head_blk.data;
  assign bus.fifo_count      = fifo_count;
  assign bus.flush_pending   = (state_q == FLUSH_PENDING);

endmodule

// File: tb/tb_ife_block_packer.sv
// tb/tb_ife_block_packer.sv - randomized bench for ife_block_packer against a transaction-level model
module tb_ife_block_packer;

  localparam int DEPTH = 4;
  localparam int ID_W  = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [7:0]   id;
    logic [127:0] data;
  } blk_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ife_block_packer_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  ife_block_packer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  blk_t        exp_q[$];
  logic [31:0] part_q[$];
  int          m_id;
  bit          m_pend;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return !m_pend && (part_q.size() != 3 || exp_q.size() < DEPTH);
  endfunction

  function automatic blk_t make_blk();
    blk_t b;
    b.id = m_id[7:0];
    for (int i = 0; i < 4; i++) b.data[i*32 +: 32] = (i < part_q.size()) ? part_q[i] : NOP;
    return b;
  endfunction

  task automatic check_outputs();
    chk("valid", bus.block_valid_out, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("id", bus.block_id_out, exp_q[0].id);
      chk("data", bus.block_data_out, exp_q[0].data);
    end
    chk("count", bus.fifo_count, exp_q.size());
    chk("pending", bus.flush_pending, m_pend);
    chk("ready", bus.instr_ready, exp_ready());
  endtask

  task automatic cycle(input bit v, input logic [31:0] w, input bit f, input bit r);
    bit   rdy;
    bit   full;
    bit   do_push;
    blk_t nb;
    bus.instr_valid    = v;
    bus.instr_in       = w;
    bus.flush          = f;
    bus.block_ready_in = r;
    check_outputs();
    rdy     = exp_ready();
    full    = (exp_q.size() == DEPTH);
    do_push = 1'b0;
    if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
    if (m_pend) begin
      if (!full) begin
        m_pend = 1'b0;
        if (part_q.size() != 0) begin
          nb      = make_blk();
          do_push = 1'b1;
          part_q.delete();
        end
      end
    end else begin
      if (v && rdy) begin
        part_q.push_back(w);
        if (part_q.size() == 4) begin
          nb      = make_blk();
          do_push = 1'b1;
          part_q.delete();
        end
      end
      if (f) m_pend = 1'b1;
    end
    if (do_push) begin
      exp_q.push_back(nb);
      m_id = (m_id + 1) % 256;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.instr_valid    = 1'b0;
    bus.instr_in       = '0;
    bus.flush          = 1'b0;
    bus.block_ready_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", bus.block_valid_out, 0);
    chk("rst_id", bus.block_id_out, 0);
    chk("rst_data", bus.block_data_out, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_pending", bus.flush_pending, 0);
    chk("rst_ready", bus.instr_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    part_q.delete();
    m_id   = 0;
    m_pend = 1'b0;
  endtask

  initial begin
    do_reset();

    // basic block
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h11 * (i + 1), 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);

    // consecutive blocks
    for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);

    // partial flush, then a full block
    for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);

    // backpressure fills the FIFO and stalls at lane 3; flush waits for a pop
    for (int i = 0; i < 4 * DEPTH + 6; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    chk("bp_count", bus.fifo_count, DEPTH);
    chk("bp_ready", bus.instr_ready, 0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (DEPTH + 3) cycle(1'b0, '0, 1'b0, 1'b1);

    // flush together with the instruction that completes a block
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    cycle(1'b1, $urandom, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);

    // ID wrap
    for (int b = 0; b < 257; b++)
      for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);

    // reset mid-operation
    for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    chk("pre_rst_count", bus.fifo_count, 2);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    chk("post_rst_id", bus.block_id_out, 0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);

    // random traffic
    repeat (3000)
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    repeat (DEPTH + 6) cycle(1'b0, '0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ife_block_packer.md
# ife_block_packer

Upstream feeder for the SoC block input: packs a stream of 32-bit instructions into 4-lane instruction blocks, tags each with a sequential 8-bit block ID, and buffers completed blocks in a small FIFO. The FIFO output drives the SoC's `block_id_in`, `block_data_in` and `block_valid_in` inputs, which feed the IFE. An explicit `flush` closes a partially filled block by padding it with NOPs.

## Interface
- `DEPTH`, 4: number of block FIFO entries; must be a power of 2 and at least 2.
- `ID_W`, 8: width of the block ID.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_in`  in  32  instruction word.
- `instr_valid`  in  1  `instr_in` is valid.
- `instr_ready`  out  1  packer accepts `instr_in` this cycle.
- `flush`  in  1  single-cycle request to close the current partial block.
- `block_id_out`  out  ID_W  ID of the head FIFO block.
- `block_data_out`  out  [3:0][31:0]  lanes of the head block; lane 0 holds the oldest instruction.
- `block_valid_out`  out  1  FIFO is not empty.
- `block_ready_in`  in  1  consumer takes the head block. Tie high when driving the SoC, since it has no backpressure.
- `fifo_count`  out  $clog2(DEPTH)+1  number of occupied FIFO entries.
- `flush_pending`  out  1  a flush has been latched but not yet executed.

## Operation
- Assembly state:
  - `lane_cnt` counts 0..3.
  - A 3-entry lane register holds lanes 0..2.
  - `next_id` counts modulo 2^ID_W.
- Accepting an instruction (`instr_valid & instr_ready`):
  - If `lane_cnt` < 3, write the word to lane[`lane_cnt`] and increment `lane_cnt`.
  - If `lane_cnt` == 3, push {`next_id`, lanes 0..2, `instr_in`} into the FIFO, clear `lane_cnt` to 0, and increment `next_id`.
- `instr_ready` = !`flush_pending` && (`lane_cnt` != 3 || FIFO not full). It is driven from registered state only; there is no combinational path from `block_ready_in`.
- Flush:
  - A `flush` pulse sets `flush_pending`.
  - A pending flush executes in the first cycle the FIFO is not full, at the start of that cycle.
  - Execution with `lane_cnt` > 0: pad lanes [`lane_cnt`..3] with NOP, push the block, increment `next_id`, clear `lane_cnt`.
  - Execution with `lane_cnt` == 0: clear `flush_pending` and push nothing.
- Flush with a simultaneous instruction: the instruction is accepted first, because `flush_pending` is still 0 in that cycle. The flush is latched and executes on a later cycle.
  - If that instruction completed the block, the flush finds `lane_cnt` == 0 and is a no-op.
- FIFO:
  - Pop when `block_valid_out & block_ready_in`.
  - Push and pop in the same cycle are both performed, and `fifo_count` is unchanged.
  - A push into a full FIFO cannot occur, because `instr_ready` and the flush rule prevent it.
  - Read and write pointers wrap modulo DEPTH.
- Block IDs wrap from 2^ID_W−1 to 0 with no gap and no stall.

## Timing
- Reset:
  - All outputs are 0, except `instr_ready`, which is 1.
  - `lane_cnt`, `next_id`, the pointers and `flush_pending` are 0.
  - FIFO storage is cleared to 0.
  - A reset asserted mid-block discards partial lanes and all queued blocks.
- Latency, cycle N being the cycle that accepts the 4th instruction (or executes the flush):
  - With an empty FIFO, `block_valid_out` rises in cycle N+1, with registered ID and data.
  - The head block is held stable while `block_ready_in` is low.
- `fifo_count` and `block_valid_out` update in the cycle after the push or pop.
- `flush_pending` rises the cycle after the `flush` pulse. It falls the cycle after the flush executes, or after the no-op clear.
- Sustained throughput is 1 instruction per cycle, i.e. one block every 4 cycles, when `block_ready_in` = 1.

## Structure
- Package `ife_pkg`:
  - `IFE_NOP` = 32'h0000_0013.
  - `ife_block_t` = struct {logic [7:0] id; logic [3:0][31:0] data;}.
  - `IFE_LANES` = 4.
- Sub-module `ife_block_fifo`: a parameterised synchronous FIFO of `ife_block_t`, with push/pop, full/empty and count outputs.
- The packer top module contains the lane assembly, the ID counter and the flush FSM. The flush FSM has two states, IDLE and PENDING.

## Test plan
- Basic block: feed 0x11, 0x22, 0x33, 0x44 back-to-back with `block_ready_in` = 1 → one block with id 0 and data {0x44, 0x33, 0x22, 0x11} (lanes 3..0), `block_valid_out` high for exactly 1 cycle.
- Consecutive blocks: feed 8 instructions → blocks with id 0 then id 1, 4 cycles apart, and no instruction stall.
- Partial flush: feed 2 instructions, then `flush` → block with lanes 2 and 3 = 0x00000013; the next block has id 1.
- Backpressure: hold `block_ready_in` = 0 and feed 4·DEPTH+3 instructions → `fifo_count` = DEPTH and `instr_ready` drops at `lane_cnt` = 3. A `flush` in this state stays pending until one pop.
- ID wrap: feed 257 full blocks → IDs run …, 254, 255, 0, with data intact.
- Reset mid-operation: assert `rst` after 2 instructions with 2 blocks queued → all outputs return to reset values. The next 4 instructions form a block with id 0.
